// File: rtl/z80_alu_sequencer.sv
// Multi-cycle sequencer for the Z80 8-bit accumulator ALU group: decodes opcode bytes,
// feeds alu_8 from its own register file and writes the result back to A and F.
module z80_alu_sequencer #(
    parameter int ALU_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       instr_byte,
    input  logic             reg_we,
    input  logic [2:0]       reg_sel,
    input  logic [ALU_W-1:0] reg_wdata,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [4:0]       alu_opcode,
    input  logic [ALU_W-1:0] alu_out,
    input  logic [ALU_W-1:0] alu_status,
    output logic [ALU_W-1:0] acc,
    output logic [ALU_W-1:0] flags,
    output logic             done,
    output logic             err
);

    // Byte transfer: a byte moves only on a cycle where instr_valid and instr_ready are both
    // high; the producer holds instr_byte stable while instr_valid waits for instr_ready.
    typedef enum logic [1:0] {S_IDLE, S_IMM, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] REG_A  = 3'd7;
    localparam logic [2:0] REG_HL = 3'd6;

    state_t           state_q, state_d;
    logic [ALU_W-1:0] regs_q [8];
    logic [ALU_W-1:0] regs_d [8];
    logic [ALU_W-1:0] flags_q, flags_d;
    logic [ALU_W-1:0] imm_q, imm_d;
    logic [4:0]       op_q, op_d;
    logic             cp_q, cp_d;
    logic             use_imm_q, use_imm_d;
    logic [2:0]       rsel_q, rsel_d;
    logic             err_q, err_d;

    logic       dec_ok, dec_cp, dec_reg, dec_imm, handshake;
    logic [4:0] dec_op;

    always_comb begin
        dec_ok = 1'b1;
        dec_op = 5'd0;
        dec_cp = 1'b0;
        case (instr_byte[5:3])
            3'b000:  dec_op = 5'd0;
            3'b010:  dec_op = 5'd1;
            3'b100:  dec_op = 5'd2;
            3'b101:  dec_op = 5'd4;
            3'b110:  dec_op = 5'd3;
            3'b111: begin
                dec_op = 5'd1;
                dec_cp = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    assign dec_reg = dec_ok && (instr_byte[7:6] == 2'b10) && (instr_byte[2:0] != REG_HL);
    assign dec_imm = dec_ok && (instr_byte[7:6] == 2'b11) && (instr_byte[2:0] == 3'b110);

    assign instr_ready = (state_q == S_IDLE) || (state_q == S_IMM);
    assign handshake   = instr_valid && instr_ready;

    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        flags_d    = flags_q;
        imm_d      = imm_q;
        op_d       = op_q;
        cp_d       = cp_q;
        use_imm_d  = use_imm_q;
        rsel_d     = rsel_q;
        err_d      = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = 5'd0;

        // EXEC owns the register file so the operands it reads cannot shift under the ALU.
        if (reg_we && state_q != S_EXEC && reg_sel != REG_HL)
            regs_d[reg_sel] = reg_wdata;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    if (dec_reg || dec_imm) begin
                        op_d      = dec_op;
                        cp_d      = dec_cp;
                        use_imm_d = dec_imm;
                        rsel_d    = instr_byte[2:0];
                        state_d   = dec_imm ? S_IMM : S_EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_IMM: begin
                if (handshake) begin
                    imm_d   = instr_byte;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_a      = regs_q[REG_A];
                alu_b      = use_imm_q ? imm_q : regs_q[rsel_q];
                alu_opcode = op_q;
                flags_d    = alu_status;
                if (!cp_q)
                    regs_d[REG_A] = alu_out;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < 8; i++)
                regs_q[i] <= '0;
            flags_q   <= '0;
            imm_q     <= '0;
            op_q      <= 5'd0;
            cp_q      <= 1'b0;
            use_imm_q <= 1'b0;
            rsel_q    <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            flags_q   <= flags_d;
            imm_q     <= imm_d;
            op_q      <= op_d;
            cp_q      <= cp_d;
            use_imm_q <= use_imm_d;
            rsel_q    <= rsel_d;
            err_q     <= err_d;
        end
    end

    assign acc   = regs_q[REG_A];
    assign flags = flags_q;
    assign done  = (state_q == S_DONE);
    assign err   = err_q;

endmodule

// File: tb/tb_z80_alu_sequencer.sv
// Bench for z80_alu_sequencer: a behavioural alu_8 closes the loop; vectors, corner
// sequences and random instructions are checked against a mnemonic-level model.
module tb_z80_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_byte;
    logic       reg_we;
    logic [2:0] reg_sel;
    logic [7:0] reg_wdata;
    logic [7:0] alu_a, alu_b, alu_out, alu_status, acc, flags;
    logic [4:0] alu_opcode;
    logic       done, err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl_regs [8];
    logic [7:0] mdl_f;

    typedef struct {
        logic [7:0] opc;
        logic [7:0] immv;
        logic [7:0] a_init;
        logic [7:0] b_init;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t tbl [17];

    z80_alu_sequencer #(.ALU_W(8)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_byte(instr_byte),
        .reg_we(reg_we), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_status(alu_status),
        .acc(acc), .flags(flags), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // alu_8 behaviour: status is {S, Z, 0, H, 0, P/V, N, C}.
    function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] r;
        logic h, v, n, c;
        r = 9'd0; h = 1'b0; v = 1'b0; n = 1'b0; c = 1'b0;
        case (op)
            5'd0: begin
                r = {1'b0, a} + {1'b0, b};
                c = r[8];
                h = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            5'd1: begin
                r = {1'b0, a} - {1'b0, b};
                c = a < b;
                h = a[3:0] < b[3:0];
                v = (a[7] != b[7]) && (r[7] != a[7]);
                n = 1'b1;
            end
            5'd2: begin r = {1'b0, a & b}; h = 1'b1; v = ~^(a & b); end
            5'd3: begin r = {1'b0, a | b}; v = ~^(a | b); end
            5'd4: begin r = {1'b0, a ^ b}; v = ~^(a ^ b); end
            default: r = 9'd0;
        endcase
        return {r[7], (r[7:0] == 8'd0), 1'b0, h, 1'b0, v, n, c, r[7:0]};
    endfunction

    always_comb begin
        {alu_status, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl_regs[i] = 8'h00;
        mdl_f = 8'h00;
    endtask

    // Mnemonic view of the opcode byte.
    task automatic model_decode(input logic [7:0] opc, output bit is_reg, output bit is_imm,
                                output logic [4:0] eop, output bit is_cp);
        bit ok;
        ok = 1'b1; eop = 5'd0; is_cp = 1'b0;
        case (opc[5:3])
            3'd0: eop = 5'd0;                      // ADD
            3'd2: eop = 5'd1;                      // SUB
            3'd4: eop = 5'd2;                      // AND
            3'd5: eop = 5'd4;                      // XOR
            3'd6: eop = 5'd3;                      // OR
            3'd7: begin eop = 5'd1; is_cp = 1'b1; end
            default: ok = 1'b0;                    // ADC / SBC
        endcase
        is_reg = ok && opc[7:6] == 2'b10 && opc[2:0] != 3'd6;
        is_imm = ok && opc[7:6] == 2'b11 && opc[2:0] == 3'd6;
    endtask

    task automatic write_reg(input logic [2:0] sel, input logic [7:0] data);
        reg_we = 1'b1; reg_sel = sel; reg_wdata = data;
        @(negedge clk);
        reg_we = 1'b0;
        if (sel != 3'd6) mdl_regs[sel] = data;
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr_byte  = b;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            errors++;
            $display("FAIL send_timeout: instr_ready stayed 0 for byte 0x%0h", b);
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic run_instr(input logic [7:0] opc, input logic [7:0] immv, input int gap);
        bit is_reg, is_imm, is_cp;
        logic [4:0]  eop;
        logic [7:0]  a, b, r;
        logic [15:0] st;
        model_decode(opc, is_reg, is_imm, eop, is_cp);
        send(opc);
        if (!is_reg && !is_imm) begin
            chk("rej_err", err, 1);
            chk("rej_done", done, 0);
            chk("rej_ready", instr_ready, 1);
            chk("rej_acc", acc, mdl_regs[7]);
            chk("rej_flags", flags, mdl_f);
            return;
        end
        if (is_imm) begin
            chk("imm_ready", instr_ready, 1);
            chk("imm_opcode_idle", alu_opcode, 0);
            repeat (gap) @(negedge clk);
            send(immv);
            b = immv;
        end else begin
            b = mdl_regs[opc[2:0]];
        end
        a = mdl_regs[7];
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_opcode", alu_opcode, eop);
        chk("exec_ready", instr_ready, 0);
        case (opc[5:3])
            3'd0:    r = a + b;
            3'd2:    r = a - b;
            3'd4:    r = a & b;
            3'd5:    r = a ^ b;
            3'd6:    r = a | b;
            default: r = a;
        endcase
        st = alu_fn(eop, a, b);
        mdl_f = st[15:8];
        if (!is_cp) mdl_regs[7] = r;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_err", err, 0);
        chk("done_acc", acc, mdl_regs[7]);
        chk("done_flags", flags, mdl_f);
        chk("done_alu_idle", {alu_a, alu_b, 3'b0, alu_opcode}, 0);
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_ready", instr_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h80, 8'h00, 8'h07, 8'h07, 8'h0E};  // ADD A,B
        tbl[1]  = '{8'h90, 8'h00, 8'h10, 8'h01, 8'h0F};  // SUB B
        tbl[2]  = '{8'hA1, 8'h00, 8'hF0, 8'h3C, 8'h30};  // AND C
        tbl[3]  = '{8'hAA, 8'h00, 8'h0F, 8'hFF, 8'hF0};  // XOR D
        tbl[4]  = '{8'hB3, 8'h00, 8'h01, 8'h80, 8'h81};  // OR E
        tbl[5]  = '{8'hBC, 8'h00, 8'h05, 8'h09, 8'h05};  // CP H
        tbl[6]  = '{8'hFE, 8'h20, 8'h20, 8'h00, 8'h20};  // CP n
        tbl[7]  = '{8'hC6, 8'h01, 8'hFF, 8'h00, 8'h00};  // ADD n wrap
        tbl[8]  = '{8'hD6, 8'h01, 8'h00, 8'h00, 8'hFF};  // SUB n borrow
        tbl[9]  = '{8'hEE, 8'h55, 8'hAA, 8'h00, 8'hFF};  // XOR n
        tbl[10] = '{8'hF6, 8'h00, 8'h00, 8'h00, 8'h00};  // OR n zero
        tbl[11] = '{8'hAF, 8'h00, 8'hFF, 8'hFF, 8'h00};  // XOR A
        tbl[12] = '{8'hB8, 8'h00, 8'h07, 8'h07, 8'h07};  // CP B
        tbl[13] = '{8'h88, 8'h00, 8'h12, 8'h34, 8'h12};  // ADC rejected
        tbl[14] = '{8'h9D, 8'h00, 8'h12, 8'h34, 8'h12};  // SBC rejected
        tbl[15] = '{8'hCE, 8'h00, 8'h12, 8'h34, 8'h12};  // ADC n rejected
        tbl[16] = '{8'h45, 8'h00, 8'h12, 8'h34, 8'h12};  // LD rejected

        reset = 1'b1; instr_valid = 1'b0; instr_byte = 8'h00;
        reg_we = 1'b0; reg_sel = 3'd0; reg_wdata = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", instr_ready, 1);
        chk("rst_acc", acc, 0);
        chk("rst_flags", flags, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_alu", {alu_a, alu_b, 3'b0, alu_opcode}, 0);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].opc[7:6] == 2'b10 && tbl[i].opc[2:0] != 3'd7)
                write_reg(tbl[i].opc[2:0], tbl[i].b_init);
            write_reg(3'd7, tbl[i].a_init);
            run_instr(tbl[i].opc, tbl[i].immv, 0);
            chk("tbl_acc", acc, tbl[i].exp_acc);
        end

        // AND n with a three-cycle stall while waiting for the operand byte.
        write_reg(3'd7, 8'h0D);
        run_instr(8'hE6, 8'h07, 3);
        chk("and_n_acc", acc, 8'h05);

        // Back-to-back rejects.
        send(8'h88);
        chk("rej1_err", err, 1);
        send(8'h86);
        chk("rej2_err", err, 1);
        chk("rej2_ready", instr_ready, 1);
        send(8'h00);
        chk("rej3_err", err, 1);
        chk("rej3_done", done, 0);
        @(negedge clk);
        chk("rej_end_err", err, 0);
        chk("rej_acc_kept", acc, mdl_regs[7]);
        chk("rej_flags_kept", flags, mdl_f);

        // Reset while waiting for an immediate drops the instruction.
        write_reg(3'd7, 8'h44);
        send(8'hC6);
        chk("imm_wait_ready", instr_ready, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("rst_imm_acc", acc, 0);
        chk("rst_imm_flags", flags, 0);
        chk("rst_imm_ready", instr_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_imm_no_done", done, 0);
        end
        write_reg(3'd0, 8'h03);
        run_instr(8'h80, 8'h00, 0);
        chk("post_rst_opcode_acc", acc, 8'h03);

        // reg_we during EXEC is ignored.
        write_reg(3'd7, 8'h01);
        write_reg(3'd0, 8'h02);
        send(8'h80);
        reg_we = 1'b1; reg_sel = 3'd7; reg_wdata = 8'h55;
        chk("exec_we_alu_a", alu_a, 8'h01);
        @(negedge clk);
        reg_we = 1'b0;
        mdl_regs[7] = 8'h03;
        mdl_f = alu_fn(5'd0, 8'h01, 8'h02) >> 8;
        chk("exec_we_done", done, 1);
        chk("exec_we_acc", acc, 8'h03);
        @(negedge clk);

        // reg_we on the decode handshake edge is seen by that instruction.
        write_reg(3'd7, 8'h01);
        reg_we = 1'b1; reg_sel = 3'd0; reg_wdata = 8'h09;
        send(8'h80);
        reg_we = 1'b0;
        mdl_regs[0] = 8'h09;
        chk("hs_we_alu_b", alu_b, 8'h09);
        @(negedge clk);
        mdl_regs[7] = 8'h0A;
        mdl_f = alu_fn(5'd0, 8'h01, 8'h09) >> 8;
        chk("hs_we_acc", acc, 8'h0A);
        chk("hs_we_flags", flags, mdl_f);
        @(negedge clk);

        for (int it = 0; it < 200; it++) begin
            logic [7:0] opc;
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++)
                write_reg(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) != 0) opc = 8'($urandom_range(128, 255));
            else                           opc = 8'($urandom_range(0, 255));
            run_instr(opc, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
